// File: rtl/nibble_sort_pkg.sv
// Shared types and sizing for the nibble sort sequencer and its 4x4 sorter.
// Contents:
//   LANES / LANE_W  frame geometry (4 lanes of 4 bits)
//   lane_t          one lane value
//   state_t         sequencer FSM states
package nibble_sort_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 4;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_sorter.sv
// Combinational 4-lane nibble sorter, placed beside the sequencer at integration.
// Ports:
//   i  in   16  unsorted frame, lane k at [4*k +: 4]
//   o  out  16  sorted frame, lane 0 = minimum, lane 3 (MSBs) = maximum
module nibble_sorter
  import nibble_sort_pkg::*;
(
  input  logic [LANES*LANE_W-1:0] i,
  output logic [LANES*LANE_W-1:0] o
);

  lane_t v [LANES];
  lane_t t;

  // Five-comparator optimal network for four inputs.
  always_comb begin
    t = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      v[k] = i[LANE_W*k +: LANE_W];
    end
    if (v[0] > v[1]) begin t = v[0]; v[0] = v[1]; v[1] = t; end
    if (v[2] > v[3]) begin t = v[2]; v[2] = v[3]; v[3] = t; end
    if (v[0] > v[2]) begin t = v[0]; v[0] = v[2]; v[2] = t; end
    if (v[1] > v[3]) begin t = v[1]; v[1] = v[3]; v[3] = t; end
    if (v[1] > v[2]) begin t = v[1]; v[1] = v[2]; v[2] = t; end
    o = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      o[LANE_W*k +: LANE_W] = v[k];
    end
  end

endmodule

// File: rtl/nibble_sort_sequencer.sv
// Streaming front/back end for the external combinational nibble sorter:
// collects N nibbles into a frame, captures the sorted result, and streams it
// out ascending with a last marker.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready/in_data     upstream nibble handshake
//   sort_in              frame to sorter, lane k at [W*k +: W]
//   sort_out             sorter result, lane 0 = minimum
//   out_valid/out_ready/out_data  downstream nibble handshake
//   out_last             marks the final nibble of a frame
//   busy                 high while sorting or emitting
module nibble_sort_sequencer
  import nibble_sort_pkg::*;
#(
  parameter int unsigned W = LANE_W,
  parameter int unsigned N = LANES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic [N*W-1:0] sort_in,
  input  logic [N*W-1:0] sort_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic           busy
);

  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N*W-1:0]   frame;
  logic [N*W-1:0]   result;

  // State, lane counter, frame and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOAD;
      cnt    <= '0;
      frame  <= '0;
      result <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            frame[W*cnt +: W] <= in_data;
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= SORT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        SORT: begin
          // Frame has been stable on sort_in for this whole cycle.
          result <= sort_out;
          state  <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= LOAD;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          cnt   <= '0;
          state <= LOAD;
        end
      endcase
    end
  end

  // Outputs decode purely from registered state, so they hold under backpressure.
  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == EMIT);
    busy      = (state == SORT) || (state == EMIT);
    out_last  = (state == EMIT) && (cnt == CNT_LAST);
    out_data  = result[W*cnt +: W];
    sort_in   = frame;
  end

endmodule
